// File: rtl/expansion_bus_slave_if.sv
// Register-request bus between the expansion-port slave and the cartridge
// register file / DMA controller.
//   req_valid/req_we/req_addr/req_wdata : single-beat request (slave -> regfile)
//   req_ready                           : request accepted this cycle
//   rsp_valid/rsp_data                  : one-cycle read-data pulse
// Modports: master = request issuer (expansion_bus_slave), slave = register file.
interface expansion_bus_slave_if #(
  parameter int unsigned ADDR_BITS = 8
) ();
  logic                 req_valid;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [7:0]           req_wdata;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [7:0]           rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/expansion_bus_slave.sv
// C64 expansion-port I/O slave. Turns IO1/IO2 window cycles into single-beat
// register requests and drives read data back onto the port during PHI2 high.
// Ports:
//   clk, rst                 : system clock, async active-high reset
//   full_m1/full_p0/half_p1  : pre-aligned PHI2 phase strobes
//   a, d_in, rw, io1_n, io2_n: raw expansion-port inputs (synchronised here)
//   d_out, d_oe              : port data and output enable
//   bus                      : register request/response bus (master side)
//   miss_count               : saturating count of late/missing reads and
//                              dropped cycles
module expansion_bus_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_BITS   = 8,
  parameter logic [7:0]  OPEN_BUS    = 8'hFF,
  parameter bit          USE_IO1     = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        full_m1,
  input  logic                        full_p0,
  input  logic                        half_p1,
  input  logic [15:0]                 a,
  input  logic [7:0]                  d_in,
  input  logic                        rw,
  input  logic                        io1_n,
  input  logic                        io2_n,
  output logic [7:0]                  d_out,
  output logic                        d_oe,
  expansion_bus_slave_if.master       bus,
  output logic [7:0]                  miss_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_REQ
  } state_t;

  // Synchroniser word: {addr, data, rw, select_n}. The window select is
  // chosen before the flops since USE_IO1 is static.
  localparam int unsigned SYNC_W = ADDR_BITS + 10;
  localparam logic [SYNC_W-1:0] SYNC_RST = {{(ADDR_BITS + 8){1'b0}}, 2'b11};

  logic [SYNC_W-1:0]    sync_d [SYNC_STAGES];
  logic [SYNC_W-1:0]    sync_q [SYNC_STAGES];
  logic [ADDR_BITS-1:0] a_s;
  logic [7:0]           d_s;
  logic                 rw_s;
  logic                 sel_n_s;
  logic                 sel_s;
  logic                 sel_n_raw;

  assign sel_n_raw = USE_IO1 ? io1_n : io2_n;

  always_comb begin
    sync_d[0] = {a[ADDR_BITS-1:0], d_in, rw, sel_n_raw};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_RST;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign {a_s, d_s, rw_s, sel_n_s} = sync_q[SYNC_STAGES-1];
  assign sel_s = ~sel_n_s;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           d_out_q, d_out_d;
  logic                 d_oe_q, d_oe_d;
  logic [7:0]           miss_q, miss_d;
  logic                 miss_inc;
  logic                 start;

  assign start = half_p1 && sel_s;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      d_out_q <= '0;
      d_oe_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      d_out_q <= d_out_d;
      d_oe_q  <= d_oe_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic. A read timeout goes through RD_DRIVE rather than
  // straight to IDLE so the one-clk OPEN_BUS pulse is dropped by the same
  // full_p0 rule as a normal read; the response path is already closed there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = rw_s ? RD_REQ : WR_WAIT;
      end
      RD_REQ: begin
        if (bus.req_ready && bus.rsp_valid) state_d = RD_DRIVE;
        else if (full_m1)                   state_d = RD_DRIVE;
        else if (bus.req_ready)             state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.rsp_valid || full_m1) state_d = RD_DRIVE;
      end
      RD_DRIVE: begin
        if (full_p0) state_d = IDLE;
      end
      WR_WAIT: begin
        if (full_m1) state_d = WR_REQ;
      end
      WR_REQ: begin
        if (bus.req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    d_out_d  = d_out_q;
    d_oe_d   = d_oe_q;
    miss_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        d_oe_d = 1'b0;
        if (start) addr_d = a_s;
      end
      RD_REQ: begin
        if (bus.req_ready && bus.rsp_valid) begin
          d_out_d = bus.rsp_data;
          d_oe_d  = 1'b1;
        end else if (full_m1) begin
          d_out_d  = OPEN_BUS;
          d_oe_d   = 1'b1;
          miss_inc = 1'b1;
        end
      end
      RD_WAIT: begin
        if (bus.rsp_valid) begin
          d_out_d = bus.rsp_data;
          d_oe_d  = 1'b1;
        end else if (full_m1) begin
          d_out_d  = OPEN_BUS;
          d_oe_d   = 1'b1;
          miss_inc = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (full_p0) d_oe_d = 1'b0;
      end
      WR_WAIT: begin
        d_oe_d = 1'b0;
        if (full_m1) wdata_d = d_s;
      end
      WR_REQ: begin
        d_oe_d = 1'b0;
        // A new selected cycle under write backpressure is dropped.
        if (start) miss_inc = 1'b1;
      end
      default: d_oe_d = 1'b0;
    endcase
    miss_d = (miss_inc && (miss_q != 8'hFF)) ? miss_q + 8'd1 : miss_q;
  end

  assign bus.req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign bus.req_we    = (state_q == WR_REQ);
  assign bus.req_addr  = addr_q;
  assign bus.req_wdata = wdata_q;
  assign d_out         = d_out_q;
  assign d_oe          = d_oe_q;
  assign miss_count    = miss_q;

endmodule
